stdp_pair_scheduler: RTL and testbench

- Sequences one coupled-STDP timestep for a pre/post Izhikevich neuron pair (neuron 1 = pre, neuron 2 = post).
- Per accepted apply: strobes both neurons once, waits for completion, timestamps spikes, and requests a weight delta from the STDP datapath when a pre/post pair falls inside the window.
- Applies the returned delta to the synaptic weight with saturation.
- Sits between the top-level apply source and the neuron/STDP datapaths.

---
 rtl/stdp_pkg.sv | 23 ++
 rtl/sat_add_sub.sv | 36 +++
 rtl/stdp_pair_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_stdp_pair_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// rtl/stdp_pkg.sv - shared types and defaults for the STDP pair scheduler
// Contents: scheduler state enum, default word/counter widths, STDP window, Q16 unity.
package stdp_pkg;

    localparam int STDP_N      = 32;
    localparam int STDP_Q      = 16;
    localparam int STDP_TW     = 16;
    localparam int STDP_WINDOW = 64;

    localparam logic [STDP_N-1:0] ONE = 32'h0001_0000;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        WAIT_N,
        EVAL,
        REQ,
        WAIT_DW,
        UPDATE,
        RETIRE
    } state_t;

endpackage

// File: rtl/sat_add_sub.sv
// rtl/sat_add_sub.sv - signed weight plus/minus unsigned magnitude with one-sided clamp
// Ports: a (signed weight), b (unsigned magnitude), sub (1 = a-b), lo/hi (signed bounds), y (result).
// Addition clamps only against hi, subtraction only against lo.
module sat_add_sub #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic [N-1:0] lo,
    input  logic [N-1:0] hi,
    output logic [N-1:0] y
);

    logic signed [N:0] a_x;
    logic signed [N:0] b_x;
    logic signed [N:0] lo_x;
    logic signed [N:0] hi_x;
    logic signed [N:0] r;

    always_comb begin
        a_x  = {a[N-1], a};
        b_x  = {1'b0, b};
        lo_x = {lo[N-1], lo};
        hi_x = {hi[N-1], hi};
        r    = sub ? (a_x - b_x) : (a_x + b_x);
        y    = r[N-1:0];
        if (!sub && (r > hi_x)) begin
            y = hi;
        end
        if (sub && (r < lo_x)) begin
            y = lo;
        end
    end

endmodule

// File: rtl/stdp_pair_scheduler.sv
// rtl/stdp_pair_scheduler.sv - sequences one coupled-STDP timestep for a pre/post neuron pair
// Ports: clk, rst (async active-low); apply/load/weight_init/w_min/w_max from the apply source;
// step_en/neuron_done/is_spiking1/is_spiking2 to the neurons; stdp_start/stdp_dt/stdp_ltp/
// stdp_done/stdp_dw to the STDP datapath; weight, iteration_count, busy, step_done status.
// Option macro: PENDING_APPLY_EN queues one apply received while busy.
module stdp_pair_scheduler
    import stdp_pkg::*;
#(
    parameter int N      = STDP_N,
    parameter int TW     = STDP_TW,
    parameter int WINDOW = STDP_WINDOW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          apply,
    input  logic          load,
    input  logic [N-1:0]  weight_init,
    input  logic [N-1:0]  w_min,
    input  logic [N-1:0]  w_max,
    output logic          step_en,
    input  logic          neuron_done,
    input  logic          is_spiking1,
    input  logic          is_spiking2,
    output logic          stdp_start,
    output logic [TW-1:0] stdp_dt,
    output logic          stdp_ltp,
    input  logic          stdp_done,
    input  logic [N-1:0]  stdp_dw,
    output logic [N-1:0]  weight,
    output logic [TW-1:0] iteration_count,
    output logic          busy,
    output logic          step_done
);

    state_t        state;
    state_t        state_nxt;
    logic          spk1_q;
    logic          spk2_q;
    logic [TW-1:0] t_pre;
    logic [TW-1:0] t_post;
    logic          pre_valid;
    logic          post_valid;
    logic [N-1:0]  dw_q;
    logic [N-1:0]  weight_nxt;
    logic [TW-1:0] dt_pre;
    logic [TW-1:0] dt_post;
    logic          eval_req;
    logic          eval_ltp;
    logic [TW-1:0] eval_dt;
    logic          requeue;

    // Modulo-2^TW differences keep counter wrap transparent.
    always_comb begin
        dt_pre   = iteration_count - t_pre;
        dt_post  = iteration_count - t_post;
        eval_req = 1'b0;
        eval_ltp = 1'b0;
        eval_dt  = '0;
        if (spk1_q && spk2_q) begin
            eval_req = 1'b1;
            eval_ltp = 1'b1;
        end else if (spk2_q && pre_valid && (dt_pre < TW'(WINDOW))) begin
            eval_req = 1'b1;
            eval_ltp = 1'b1;
            eval_dt  = dt_pre;
        end else if (spk1_q && post_valid && (dt_post < TW'(WINDOW))) begin
            eval_req = 1'b1;
            eval_dt  = dt_post;
        end
    end

`ifdef PENDING_APPLY_EN
    logic pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
        end else if (state == RETIRE) begin
            pending <= 1'b0;
        end else if ((state != IDLE) && apply) begin
            pending <= 1'b1;
        end
    end

    // An apply arriving during RETIRE itself is consumed directly.
    assign requeue = pending || apply;
`else
    assign requeue = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        step_en    = 1'b0;
        stdp_start = 1'b0;
        step_done  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (apply && !load) state_nxt = STEP;
            STEP: begin
                step_en   = 1'b1;
                state_nxt = WAIT_N;
            end
            WAIT_N:  if (neuron_done) state_nxt = EVAL;
            EVAL:    state_nxt = eval_req ? REQ : RETIRE;
            REQ: begin
                stdp_start = 1'b1;
                state_nxt  = WAIT_DW;
            end
            WAIT_DW: if (stdp_done) state_nxt = UPDATE;
            UPDATE:  state_nxt = RETIRE;
            RETIRE: begin
                step_done = 1'b1;
                state_nxt = requeue ? STEP : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    sat_add_sub #(.N(N)) u_sat (
        .a   (weight),
        .b   (dw_q),
        .sub (!stdp_ltp),
        .lo  (w_min),
        .hi  (w_max),
        .y   (weight_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            weight          <= '0;
            iteration_count <= '0;
            stdp_dt         <= '0;
            stdp_ltp        <= 1'b0;
            t_pre           <= '0;
            t_post          <= '0;
            pre_valid       <= 1'b0;
            post_valid      <= 1'b0;
            spk1_q          <= 1'b0;
            spk2_q          <= 1'b0;
            dw_q            <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (load) begin
                        weight          <= weight_init;
                        iteration_count <= '0;
                        t_pre           <= '0;
                        t_post          <= '0;
                        pre_valid       <= 1'b0;
                        post_valid      <= 1'b0;
                    end
                end
                WAIT_N: begin
                    if (neuron_done) begin
                        spk1_q <= is_spiking1;
                        spk2_q <= is_spiking2;
                    end
                end
                EVAL: begin
                    // dt above already used the previous timestamps.
                    if (spk1_q) begin
                        t_pre     <= iteration_count;
                        pre_valid <= 1'b1;
                    end
                    if (spk2_q) begin
                        t_post     <= iteration_count;
                        post_valid <= 1'b1;
                    end
                    if (eval_req) begin
                        stdp_dt  <= eval_dt;
                        stdp_ltp <= eval_ltp;
                    end
                end
                WAIT_DW: if (stdp_done) dw_q <= stdp_dw;
                UPDATE:  weight <= weight_nxt;
                RETIRE:  iteration_count <= iteration_count + TW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stdp_pair_scheduler.sv
// tb/tb_stdp_pair_scheduler.sv - directed self-checking bench for stdp_pair_scheduler
module tb_stdp_pair_scheduler;
    import stdp_pkg::*;

    // Narrow counter so the 2^TW wrap is reachable in a short run.
    localparam int N      = 32;
    localparam int TW     = 8;
    localparam int WINDOW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          apply = 1'b0;
    logic          load = 1'b0;
    logic [N-1:0]  weight_init = '0;
    logic [N-1:0]  w_min = 32'hFFFF_0000;
    logic [N-1:0]  w_max = 32'h0002_0000;
    logic          step_en;
    logic          neuron_done = 1'b0;
    logic          is_spiking1 = 1'b0;
    logic          is_spiking2 = 1'b0;
    logic          stdp_start;
    logic [TW-1:0] stdp_dt;
    logic          stdp_ltp;
    logic          stdp_done = 1'b0;
    logic [N-1:0]  stdp_dw = '0;
    logic [N-1:0]  weight;
    logic [TW-1:0] iteration_count;
    logic          busy;
    logic          step_done;

    int            tests = 0;
    int            fails = 0;
    int            starts = 0;
    int            steps = 0;
    logic [TW-1:0] last_dt = '0;
    logic          last_ltp = 1'b0;
    logic          r;
    int            s0;
    int            e0;

    stdp_pair_scheduler #(.N(N), .TW(TW), .WINDOW(WINDOW)) dut (
        .clk             (clk),
        .rst             (rst),
        .apply           (apply),
        .load            (load),
        .weight_init     (weight_init),
        .w_min           (w_min),
        .w_max           (w_max),
        .step_en         (step_en),
        .neuron_done     (neuron_done),
        .is_spiking1     (is_spiking1),
        .is_spiking2     (is_spiking2),
        .stdp_start      (stdp_start),
        .stdp_dt         (stdp_dt),
        .stdp_ltp        (stdp_ltp),
        .stdp_done       (stdp_done),
        .stdp_dw         (stdp_dw),
        .weight          (weight),
        .iteration_count (iteration_count),
        .busy            (busy),
        .step_done       (step_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && stdp_start) starts++;
        if (rst && step_en) steps++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_step();
        apply = 1'b1;
        @(negedge clk);
        apply = 1'b0;
        check("apply_to_step_en", step_en, 1);
    endtask

    task automatic feed(input logic s1, input logic s2, output logic req);
        @(negedge clk);
        neuron_done = 1'b1;
        is_spiking1 = s1;
        is_spiking2 = s2;
        @(negedge clk);
        neuron_done = 1'b0;
        is_spiking1 = 1'b0;
        is_spiking2 = 1'b0;
        @(negedge clk);
        req = stdp_start;
        if (req) begin
            last_dt  = stdp_dt;
            last_ltp = stdp_ltp;
        end else begin
            check("retire_latency", step_done, 1);
        end
    endtask

    task automatic finish_req(input logic [N-1:0] dw, input logic apply_mid);
        @(negedge clk);
        check("dt_held", stdp_dt, last_dt);
        if (apply_mid) apply = 1'b1;
        @(negedge clk);
        apply     = 1'b0;
        stdp_done = 1'b1;
        stdp_dw   = dw;
        @(negedge clk);
        stdp_done = 1'b0;
        @(negedge clk);
        check("retire_after_update", step_done, 1);
    endtask

    task automatic do_step(input logic s1, input logic s2, input logic [N-1:0] dw, output logic req);
        start_step();
        feed(s1, s2, req);
        if (req) finish_req(dw, 1'b0);
        @(negedge clk);
    endtask

    task automatic idle_steps(input int k);
        logic q;
        for (int i = 0; i < k; i++) do_step(1'b0, 1'b0, '0, q);
    endtask

    task automatic load_w(input logic [N-1:0] v);
        load        = 1'b1;
        weight_init = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_weight", weight, 0);
        check("rst_iter", iteration_count, 0);
        check("rst_step_en", step_en, 0);
        check("rst_stdp_start", stdp_start, 0);
        check("rst_dt", stdp_dt, 0);
        check("rst_ltp", stdp_ltp, 0);
        check("rst_busy", busy, 0);
        check("rst_step_done", step_done, 0);
        rst = 1'b1;
        @(negedge clk);

        // load beats a simultaneous apply
        apply = 1'b1;
        load_w(ONE);
        apply = 1'b0;
        check("load_weight", weight, 32'h0001_0000);
        check("load_busy", busy, 0);
        @(negedge clk);
        check("load_apply_dropped", steps, 0);

        // post-after-pre
        idle_steps(3);
        do_step(1'b1, 1'b0, '0, r);
        check("pre_only_no_req", r, 0);
        idle_steps(3);
        do_step(1'b0, 1'b1, 32'h0000_4000, r);
        check("ltp_req", r, 1);
        check("ltp_dt", last_dt, 4);
        check("ltp_flag", last_ltp, 1);
        check("ltp_weight", weight, 32'h0001_4000);
        check("ltp_iter", iteration_count, 8);

        // pre-after-post
        load_w(ONE);
        idle_steps(10);
        do_step(1'b0, 1'b1, '0, r);
        check("post_no_partner", r, 0);
        idle_steps(1);
        do_step(1'b1, 1'b0, 32'h0000_8000, r);
        check("ltd_req", r, 1);
        check("ltd_dt", last_dt, 2);
        check("ltd_flag", last_ltp, 0);
        check("ltd_weight", weight, 32'h0000_8000);

        // saturation at both bounds
        load_w(32'h0001_F000);
        do_step(1'b1, 1'b0, '0, r);
        do_step(1'b0, 1'b1, 32'h0000_4000, r);
        check("sat_hi_dt", last_dt, 1);
        check("sat_hi_weight", weight, 32'h0002_0000);
        w_min = 32'h0001_8000;
        do_step(1'b1, 1'b0, 32'h0001_0000, r);
        check("sat_lo_flag", last_ltp, 0);
        check("sat_lo_weight", weight, 32'h0001_8000);
        w_min = 32'hFFFF_0000;

        // window edge: dt=64 ignored, dt=63 accepted
        load_w(ONE);
        do_step(1'b1, 1'b0, '0, r);
        idle_steps(63);
        s0 = starts;
        do_step(1'b0, 1'b1, 32'h0000_4000, r);
        check("win64_no_req", r, 0);
        check("win64_no_start", starts, s0);
        check("win64_weight", weight, 32'h0001_0000);
        idle_steps(62);
        do_step(1'b1, 1'b0, 32'h0000_1000, r);
        check("win63_req", r, 1);
        check("win63_dt", last_dt, 63);
        check("win63_weight", weight, 32'h0000_F000);

        // counter wrap: pre at 0xFE, post at 0x01
        idle_steps(126);
        check("pre_wrap_iter", iteration_count, 8'hFE);
        do_step(1'b1, 1'b0, '0, r);
        check("far_partner_no_req", r, 0);
        idle_steps(2);
        check("wrapped_iter", iteration_count, 1);
        do_step(1'b0, 1'b1, 32'h0000_1000, r);
        check("wrap_req", r, 1);
        check("wrap_dt", last_dt, 3);
        check("wrap_ltp", last_ltp, 1);
        check("wrap_weight", weight, 32'h0001_0000);

        // simultaneous spikes with an apply pulsed during WAIT_DW
        s0 = starts;
        e0 = steps;
        start_step();
        feed(1'b1, 1'b1, r);
        check("sim_req", r, 1);
        check("sim_dt", last_dt, 0);
        check("sim_ltp", last_ltp, 1);
        finish_req(32'h0000_1000, 1'b1);
`ifdef PENDING_APPLY_EN
        @(negedge clk);
        check("queued_step_en", step_en, 1);
        feed(1'b0, 1'b0, r);
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("queued_steps", steps - e0, 2);
        check("queued_iter", iteration_count, 4);
`else
        repeat (4) @(negedge clk);
        check("dropped_steps", steps - e0, 1);
        check("dropped_iter", iteration_count, 3);
`endif
        check("sim_one_start", starts - s0, 1);
        check("sim_weight", weight, 32'h0001_1000);
        check("sim_idle", busy, 0);

        // async reset inside WAIT_DW, then stray done pulses
        start_step();
        feed(1'b1, 1'b0, r);
        check("pre_rst_req", r, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_weight", weight, 0);
        check("arst_busy", busy, 0);
        check("arst_iter", iteration_count, 0);
        check("arst_dt", stdp_dt, 0);
        check("arst_ltp", stdp_ltp, 0);
        check("arst_start", stdp_start, 0);
        @(negedge clk);
        rst = 1'b1;
        s0 = starts;
        @(negedge clk);
        stdp_done   = 1'b1;
        stdp_dw     = 32'h0000_4000;
        neuron_done = 1'b1;
        @(negedge clk);
        stdp_done   = 1'b0;
        neuron_done = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_weight", weight, 0);
        check("stray_busy", busy, 0);
        check("stray_start", starts, s0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
